// File: rtl/real_dom_sqscmul_gf2_pipe.sv
`default_nettype none
// ============================================================================
// Module      : real_dom_sqscmul_gf2_pipe
// Description : DOM-masked GF(2^4) "square-scale plus multiply" datapath.
//               Each lane takes A (bits 3:2) and B (bits 1:0) in SHARES
//               Boolean shares and produces E = sqsc(A^B) ^ mul(A,B) in
//               SHARES Boolean shares, with a valid/ready pipeline of
//               STAGES (1 or 2) register stages.
//               Optional macro SQSCMUL_UNMASK_CHECK_EN adds a debug checker
//               that recomputes the unmasked result and raises a sticky
//               ErrxSO on any mismatch at the output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module real_dom_sqscmul_gf2_pipe #(
  parameter int SHARES = 2,
  parameter int LANES  = 1,
  parameter int STAGES = 1
) (
  input  logic                              ClkxCI,
  input  logic                              RstxSI,
  input  logic [LANES*4*SHARES-1:0]         _XxDI,
  input  logic [LANES*SHARES*(SHARES-1)-1:0] _ZxDI,
  input  logic                              InValidxSI,
  output logic                              InReadyxSO,
  output logic [LANES*2*SHARES-1:0]         _QxDO,
  output logic                              OutValidxSO,
  input  logic                              OutReadyxSI,
  output logic                              ErrxSO
);

  // Randomness bits per lane (2 bits per unordered share pair).
  localparam int ZPL = SHARES * (SHARES - 1);
  // One 2-bit term per (lane, share i, share j); the diagonal i==j holds
  // the inner-domain term so all terms are registered in the same stage.
  localparam int TW  = LANES * SHARES * SHARES * 2;
  localparam int QW  = LANES * SHARES * 2;

  function automatic logic [1:0] gf_mul(input logic [1:0] a, input logic [1:0] b);
    logic t;
    t = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ t, (a[0] & b[0]) ^ t};
  endfunction

  function automatic logic [1:0] gf_sqsc(input logic [1:0] s);
    return {s[0], s[1] ^ s[0]};
  endfunction

  // Lexicographic index of the unordered pair (lo, hi), lo < hi.
  function automatic int pair_idx(input int lo, input int hi);
    return lo * SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  logic          en1;
  logic          accept;
  logic          valid1_q, valid1_d;
  logic [TW-1:0] term_q, term_d;
  logic [QW-1:0] recomb;

  assign accept     = InValidxSI & en1;
  assign InReadyxSO = en1;

  // Stage-1 next state: terms are computed from the inputs but only loaded on
  // an accepted beat, so a stall holds every share and ignores _ZxDI.
  always_comb begin
    logic [1:0] ai, bi, bj, zr, v;
    term_d   = term_q;
    valid1_d = valid1_q;
    ai = '0; bi = '0; bj = '0; zr = '0; v = '0;
    if (en1) valid1_d = InValidxSI;
    for (int l = 0; l < LANES; l++) begin
      for (int i = 0; i < SHARES; i++) begin
        for (int j = 0; j < SHARES; j++) begin
          ai = _XxDI[(l*SHARES + i)*4 + 2 +: 2];
          bi = _XxDI[(l*SHARES + i)*4 +: 2];
          bj = _XxDI[(l*SHARES + j)*4 +: 2];
          if (i == j) begin
            v = gf_mul(ai, bi) ^ gf_sqsc(ai ^ bi);
          end else begin
            if (i < j) zr = _ZxDI[l*ZPL + 2*pair_idx(i, j) +: 2];
            else       zr = _ZxDI[l*ZPL + 2*pair_idx(j, i) +: 2];
            v = gf_mul(ai, bj) ^ zr;
          end
          if (accept) term_d[((l*SHARES + i)*SHARES + j)*2 +: 2] = v;
        end
      end
    end
  end

  // Stage-1 registers: inner and cross-domain terms, plus beat valid.
  always_ff @(posedge ClkxCI or posedge RstxSI) begin
    if (RstxSI) begin
      valid1_q <= 1'b0;
      term_q   <= '0;
    end else begin
      valid1_q <= valid1_d;
      term_q   <= term_d;
    end
  end

  // Recombine only registered terms: output share i = XOR over j of term(i,j).
  always_comb begin
    recomb = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int i = 0; i < SHARES; i++) begin
        for (int j = 0; j < SHARES; j++) begin
          recomb[(l*SHARES + i)*2 +: 2] = recomb[(l*SHARES + i)*2 +: 2]
                                        ^ term_q[((l*SHARES + i)*SHARES + j)*2 +: 2];
        end
      end
    end
  end

  generate
    if (STAGES == 2) begin : g_two_stage
      logic          en2;
      logic          valid2_q, valid2_d;
      logic [QW-1:0] q2_q, q2_d;

      assign en2 = ~valid2_q | OutReadyxSI;
      assign en1 = ~valid1_q | en2;

      // Stage-2 next state: capture recombined shares when stage 2 may advance.
      always_comb begin
        valid2_d = valid2_q;
        q2_d     = q2_q;
        if (en2) begin
          valid2_d = valid1_q;
          if (valid1_q) q2_d = recomb;
        end
      end

      // Stage-2 registers: recombined output shares.
      always_ff @(posedge ClkxCI or posedge RstxSI) begin
        if (RstxSI) begin
          valid2_q <= 1'b0;
          q2_q     <= '0;
        end else begin
          valid2_q <= valid2_d;
          q2_q     <= q2_d;
        end
      end

      assign _QxDO       = q2_q;
      assign OutValidxSO = valid2_q;
    end else begin : g_one_stage
      assign en1         = ~valid1_q | OutReadyxSI;
      assign _QxDO       = recomb;
      assign OutValidxSO = valid1_q;
    end
  endgenerate

`ifdef SQSCMUL_UNMASK_CHECK_EN
  localparam int EW = LANES * 2;
  logic [EW-1:0] exp_in, exp1_q, exp1_d, exp_out, q_plain;
  logic          err_q, err_d;

  // Unmasked reference for the incoming beat and unmasked view of the output.
  always_comb begin
    logic [1:0] a, b, q;
    exp_in  = '0;
    q_plain = '0;
    for (int l = 0; l < LANES; l++) begin
      a = '0; b = '0; q = '0;
      for (int s = 0; s < SHARES; s++) begin
        a = a ^ _XxDI[(l*SHARES + s)*4 + 2 +: 2];
        b = b ^ _XxDI[(l*SHARES + s)*4 +: 2];
        q = q ^ _QxDO[(l*SHARES + s)*2 +: 2];
      end
      exp_in[l*2 +: 2]  = gf_mul(a, b) ^ gf_sqsc(a ^ b);
      q_plain[l*2 +: 2] = q;
    end
  end

  // Checker next state: follow the data pipeline, flag any drained mismatch.
  always_comb begin
    exp1_d = exp1_q;
    if (accept) exp1_d = exp_in;
    err_d = err_q | (OutValidxSO & OutReadyxSI & (q_plain != exp_out));
  end

  // Checker registers.
  always_ff @(posedge ClkxCI or posedge RstxSI) begin
    if (RstxSI) begin
      exp1_q <= '0;
      err_q  <= 1'b0;
    end else begin
      exp1_q <= exp1_d;
      err_q  <= err_d;
    end
  end

  generate
    if (STAGES == 2) begin : g_chk_two
      logic [EW-1:0] exp2_q, exp2_d;

      // Second checker stage advances exactly like the data stage 2.
      always_comb begin
        exp2_d = exp2_q;
        if ((~OutValidxSO | OutReadyxSI) & valid1_q) exp2_d = exp1_q;
      end

      // Second checker stage register.
      always_ff @(posedge ClkxCI or posedge RstxSI) begin
        if (RstxSI) exp2_q <= '0;
        else        exp2_q <= exp2_d;
      end

      assign exp_out = exp2_q;
    end else begin : g_chk_one
      assign exp_out = exp1_q;
    end
  endgenerate

  assign ErrxSO = err_q;
`else
  assign ErrxSO = 1'b0;
`endif

endmodule
`default_nettype wire
